// File: rtl/brnch_resolve_recovery_unit_pkg.sv
// Shared definitions for the branch resolve / recovery unit.
// Holds the recovery FSM state encoding, the BEQ/BNE selector encodings,
// the statistics counter width, the sequential-PC increment and the
// branch outcome helper.
package brnch_resolve_recovery_unit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    RECOVER   = 2'd2
  } br_state_e;

  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  localparam int STAT_W = 16;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Taken outcome: operands equal for BEQ, operands differ for BNE.
  function automatic logic br_outcome(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic        br_kind);
    return (a == b) ^ (br_kind == BR_BNE);
  endfunction

endpackage

// File: rtl/brnch_resolve_recovery_unit_sat_cnt16.sv
// Saturating statistics counter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear, wins over a same-cycle increment
//   inc         increment request
//   count       current value, sticks at all-ones
module sat_cnt16
  import brnch_resolve_recovery_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/brnch_resolve_recovery_unit.sv
// Branch resolve and mispredict recovery unit.
// Tracks a fetched branch through IF/ID, resolves BEQ/BNE in ID, strobes
// the predictor update, and on a mispredict squashes IF and redirects the
// PC for one cycle. Keeps saturating branch / mispredict statistics.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   brch_instr_detectd_IF       branch fetched in IF
//   predict_br_taken            predictor output for that branch
//   pc_IF                       PC of the IF instruction
//   stall_IF_ID                 hold IF/ID register
//   rs_val_ID, rt_val_ID        forwarded operands
//   brch_is_bne_ID              0=BEQ, 1=BNE
//   brch_target_ID              computed taken target
//   brch_hazard_stall           operands not ready yet
//   cnt_clr                     synchronous statistics clear
//   brch_instr_detectd_ID       valid branch in ID
//   actual_brch_result          resolved outcome (combinational)
//   brch_resolve_valid          predictor update strobe
//   flush_IF, redirect_valid    one-cycle recovery pulse
//   redirect_pc                 corrected PC of last mispredict
//   branch_count                resolved branches
//   mispredict_count            mispredicted branches
//
// state     | meaning
// IDLE      | no branch pending, or branch resolving this cycle
// WAIT_OPND | branch in ID waiting for forwarded operands
// RECOVER   | one cycle of flush_IF / redirect_valid after mispredict
module brnch_resolve_recovery_unit
  import brnch_resolve_recovery_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brch_instr_detectd_IF,
  input  logic              predict_br_taken,
  input  logic [31:0]       pc_IF,
  input  logic              stall_IF_ID,
  input  logic [31:0]       rs_val_ID,
  input  logic [31:0]       rt_val_ID,
  input  logic              brch_is_bne_ID,
  input  logic [31:0]       brch_target_ID,
  input  logic              brch_hazard_stall,
  input  logic              cnt_clr,
  output logic              brch_instr_detectd_ID,
  output logic              actual_brch_result,
  output logic              brch_resolve_valid,
  output logic              flush_IF,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  br_state_e   state;
  logic        recover_q;
  logic        is_br_ID;
  logic        pred_ID;
  logic [31:0] pc_plus4_ID;
  logic        mismatch;
  logic        mispredict;

  // IF/ID stage. A flush kills the captured branch even while stalled so a
  // wrong-path branch can never resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_br_ID    <= 1'b0;
      pred_ID     <= 1'b0;
      pc_plus4_ID <= '0;
    end else begin
      if (flush_IF) begin
        is_br_ID <= 1'b0;
      end else if (!stall_IF_ID) begin
        is_br_ID <= brch_instr_detectd_IF;
      end
      if (!stall_IF_ID) begin
        pred_ID     <= predict_br_taken;
        pc_plus4_ID <= pc_IF + PC_INCR;
      end
    end
  end

  assign brch_instr_detectd_ID = is_br_ID;
  assign actual_brch_result    = br_outcome(rs_val_ID, rt_val_ID, brch_is_bne_ID);
  assign brch_resolve_valid    = is_br_ID & ~brch_hazard_stall & (state != RECOVER);
  assign mismatch              = actual_brch_result != pred_ID;
  assign mispredict            = brch_resolve_valid & mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      recover_q   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      recover_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_br_ID && brch_hazard_stall) begin
            state <= WAIT_OPND;
          end else if (mispredict) begin
            state     <= RECOVER;
            recover_q <= 1'b1;
          end
        end
        WAIT_OPND: begin
          if (!brch_hazard_stall) begin
            if (mispredict) begin
              state     <= RECOVER;
              recover_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (mispredict) begin
        redirect_pc <= actual_brch_result ? brch_target_ID : pc_plus4_ID;
      end
    end
  end

  assign flush_IF       = recover_q;
  assign redirect_valid = recover_q;

  sat_cnt16 u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (brch_resolve_valid),
    .count (branch_count)
  );

  sat_cnt16 u_mis_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_brnch_resolve_recovery_unit.sv
module tb_brnch_resolve_recovery_unit;

  logic        clk;
  logic        rst_n;
  logic        brch_instr_detectd_IF;
  logic        predict_br_taken;
  logic [31:0] pc_IF;
  logic        stall_IF_ID;
  logic [31:0] rs_val_ID;
  logic [31:0] rt_val_ID;
  logic        brch_is_bne_ID;
  logic [31:0] brch_target_ID;
  logic        brch_hazard_stall;
  logic        cnt_clr;
  logic        brch_instr_detectd_ID;
  logic        actual_brch_result;
  logic        brch_resolve_valid;
  logic        flush_IF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks;
  int errors;

  brnch_resolve_recovery_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .brch_instr_detectd_IF (brch_instr_detectd_IF),
    .predict_br_taken      (predict_br_taken),
    .pc_IF                 (pc_IF),
    .stall_IF_ID           (stall_IF_ID),
    .rs_val_ID             (rs_val_ID),
    .rt_val_ID             (rt_val_ID),
    .brch_is_bne_ID        (brch_is_bne_ID),
    .brch_target_ID        (brch_target_ID),
    .brch_hazard_stall     (brch_hazard_stall),
    .cnt_clr               (cnt_clr),
    .brch_instr_detectd_ID (brch_instr_detectd_ID),
    .actual_brch_result    (actual_brch_result),
    .brch_resolve_valid    (brch_resolve_valid),
    .flush_IF              (flush_IF),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .branch_count          (branch_count),
    .mispredict_count      (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        bne;
    logic [31:0] tgt;
    logic        exp_act;
    logic        exp_flush;
    logic [31:0] exp_rpc;
    logic [15:0] exp_br;
    logic [15:0] exp_mis;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Branch sits in IF for one cycle, then moves to ID.
  task automatic fetch(input logic pred, input logic [31:0] pc);
    brch_instr_detectd_IF = 1'b1;
    predict_br_taken      = pred;
    pc_IF                 = pc;
    step();
    brch_instr_detectd_IF = 1'b0;
  endtask

  task automatic set_id(input logic [31:0] rs, input logic [31:0] rt, input logic bne,
                        input logic [31:0] tgt, input logic hz);
    rs_val_ID         = rs;
    rt_val_ID         = rt;
    brch_is_bne_ID    = bne;
    brch_target_ID    = tgt;
    brch_hazard_stall = hz;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 32'h0000_0040, 32'd5, 32'd5, 1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0000, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 32'h0000_0100, 32'd5, 32'd6, 1'b0, 32'h0000_0300, 1'b0, 1'b1, 32'h0000_0104, 16'd2, 16'd1};
    vecs[2] = '{1'b0, 32'h0000_0200, 32'd1, 32'd2, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0400, 16'd3, 16'd2};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'd7, 32'd7, 1'b1, 32'h0000_0999, 1'b0, 1'b0, 32'h0000_0400, 16'd4, 16'd2};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'd1, 32'd0, 1'b0, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 16'd5, 16'd3};
    vecs[5] = '{1'b1, 32'h0000_0500, 32'd3, 32'd4, 1'b1, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0000, 16'd6, 16'd3};

    rst_n                 = 1'b0;
    brch_instr_detectd_IF = 1'b0;
    predict_br_taken      = 1'b0;
    pc_IF                 = '0;
    stall_IF_ID           = 1'b0;
    rs_val_ID             = '0;
    rt_val_ID             = '0;
    brch_is_bne_ID        = 1'b0;
    brch_target_ID        = '0;
    brch_hazard_stall     = 1'b0;
    cnt_clr               = 1'b0;
    #12;
    chk("rst_is_br_id", 32'(brch_instr_detectd_ID), 32'd0);
    chk("rst_resolve", 32'(brch_resolve_valid), 32'd0);
    chk("rst_flush", 32'(flush_IF), 32'd0);
    chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_br_cnt", 32'(branch_count), 32'd0);
    chk("rst_mis_cnt", 32'(mispredict_count), 32'd0);
    chk("rst_actual_beq_eq", 32'(actual_brch_result), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      fetch(vecs[i].pred, vecs[i].pc);
      set_id(vecs[i].rs, vecs[i].rt, vecs[i].bne, vecs[i].tgt, 1'b0);
      chk($sformatf("v%0d_is_br_id", i), 32'(brch_instr_detectd_ID), 32'd1);
      chk($sformatf("v%0d_actual", i), 32'(actual_brch_result), 32'(vecs[i].exp_act));
      chk($sformatf("v%0d_resolve", i), 32'(brch_resolve_valid), 32'd1);
      chk($sformatf("v%0d_flush_early", i), 32'(flush_IF), 32'd0);
      step();
      chk($sformatf("v%0d_flush", i), 32'(flush_IF), 32'(vecs[i].exp_flush));
      chk($sformatf("v%0d_redir_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_flush));
      chk($sformatf("v%0d_redir_pc", i), redirect_pc, vecs[i].exp_rpc);
      chk($sformatf("v%0d_br_cnt", i), 32'(branch_count), 32'(vecs[i].exp_br));
      chk($sformatf("v%0d_mis_cnt", i), 32'(mispredict_count), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_resolve_after", i), 32'(brch_resolve_valid), 32'd0);
      step();
      chk($sformatf("v%0d_flush_end", i), 32'(flush_IF), 32'd0);
    end

    // Operand hazard held for three cycles on a mispredicted BNE.
    fetch(1'b0, 32'h0000_0600);
    stall_IF_ID = 1'b1;
    set_id(32'd1, 32'd2, 1'b1, 32'h0000_0200, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hz_no_strobe_c%0d", c), 32'(brch_resolve_valid), 32'd0);
      chk($sformatf("hz_is_br_c%0d", c), 32'(brch_instr_detectd_ID), 32'd1);
      step();
    end
    chk("hz_br_cnt_held", 32'(branch_count), 32'd6);
    brch_hazard_stall = 1'b0;
    stall_IF_ID       = 1'b0;
    #1;
    chk("hz_strobe", 32'(brch_resolve_valid), 32'd1);
    step();
    chk("hz_flush", 32'(flush_IF), 32'd1);
    chk("hz_redir_pc", redirect_pc, 32'h0000_0200);
    chk("hz_br_cnt", 32'(branch_count), 32'd7);
    chk("hz_mis_cnt", 32'(mispredict_count), 32'd4);
    step();
    chk("hz_flush_end", 32'(flush_IF), 32'd0);

    // Saturation: preload both counters, then mispredict.
    force dut.u_br_cnt.cnt_q = 16'hFFFF;
    force dut.u_mis_cnt.cnt_q = 16'hFFFF;
    #1;
    release dut.u_br_cnt.cnt_q;
    release dut.u_mis_cnt.cnt_q;
    #1;
    chk("sat_preset_br", 32'(branch_count), 32'h0000_FFFF);
    fetch(1'b0, 32'h0000_0800);
    set_id(32'd1, 32'd1, 1'b0, 32'h0000_0900, 1'b0);
    chk("sat_resolve", 32'(brch_resolve_valid), 32'd1);
    step();
    chk("sat_flush", 32'(flush_IF), 32'd1);
    chk("sat_redir_pc", redirect_pc, 32'h0000_0900);
    chk("sat_br_cnt", 32'(branch_count), 32'h0000_FFFF);
    chk("sat_mis_cnt", 32'(mispredict_count), 32'h0000_FFFF);
    step();

    // Clear wins over a same-cycle resolve.
    fetch(1'b0, 32'h0000_0880);
    set_id(32'd1, 32'd2, 1'b0, 32'h0000_0990, 1'b0);
    cnt_clr = 1'b1;
    #1;
    chk("clr_resolve", 32'(brch_resolve_valid), 32'd1);
    step();
    cnt_clr = 1'b0;
    chk("clr_br_cnt", 32'(branch_count), 32'd0);
    chk("clr_mis_cnt", 32'(mispredict_count), 32'd0);
    chk("clr_no_flush", 32'(flush_IF), 32'd0);
    step();

    // Branch fetched during RECOVER is squashed.
    fetch(1'b1, 32'h0000_0A00);
    set_id(32'd9, 32'd9, 1'b1, 32'h0000_0B00, 1'b0);
    step();
    chk("sq_flush", 32'(flush_IF), 32'd1);
    chk("sq_redir_pc", redirect_pc, 32'h0000_0A04);
    chk("sq_br_cnt0", 32'(branch_count), 32'd1);
    brch_instr_detectd_IF = 1'b1;
    predict_br_taken      = 1'b0;
    pc_IF                 = 32'h0000_0A04;
    step();
    brch_instr_detectd_IF = 1'b0;
    chk("sq_is_br_id", 32'(brch_instr_detectd_ID), 32'd0);
    chk("sq_no_strobe", 32'(brch_resolve_valid), 32'd0);
    step();
    chk("sq_br_cnt", 32'(branch_count), 32'd1);
    chk("sq_mis_cnt", 32'(mispredict_count), 32'd1);

    // Reset asserted mid-RECOVER cancels the pulse at once.
    fetch(1'b1, 32'h0000_0B00);
    set_id(32'd2, 32'd3, 1'b0, 32'h0000_0C00, 1'b0);
    step();
    chk("rr_flush_before", 32'(flush_IF), 32'd1);
    chk("rr_redir_pc_before", redirect_pc, 32'h0000_0B04);
    chk("rr_br_cnt_before", 32'(branch_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rr_flush", 32'(flush_IF), 32'd0);
    chk("rr_redir_valid", 32'(redirect_valid), 32'd0);
    chk("rr_redir_pc", redirect_pc, 32'd0);
    chk("rr_br_cnt", 32'(branch_count), 32'd0);
    chk("rr_mis_cnt", 32'(mispredict_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rr_flush_after", 32'(flush_IF), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
